i2s_frame_streamer: RTL

- Upstream source for the LED mask stage: reads one frame of pixel words from a synchronous-read frame buffer and serializes it MSB-first onto a gated bit clock (i2s_clk) and data line (i2s_data).
- The downstream mask stage samples i2s_data on i2s_clk rising edges and extracts its tile by addr_x/addr_y.
- Provides a frame-sync strobe and gap-free word prefetch so the bit stream is continuous for the whole frame.

---
 rtl/i2s_frame_streamer_if.sv | 16 +
 rtl/i2s_frame_streamer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_streamer_if.sv
// Frame-buffer read bus between the I2S frame streamer and its frame buffer.
// The frame buffer is synchronous-read: mem_rd_data is valid exactly one clk
// after mem_rd_en.
//   master : streamer side  (drives mem_rd_en / mem_rd_addr, takes mem_rd_data)
//   slave  : buffer side    (takes mem_rd_en / mem_rd_addr, drives mem_rd_data)
interface i2s_frame_streamer_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WORD_W-1:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_rd_addr, input  mem_rd_data);
  modport slave  (input  mem_rd_en, input  mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/i2s_frame_streamer.sv
// I2S frame streamer: on a start pulse, reads FRAME_WORDS words from a
// synchronous-read frame buffer and shifts them out MSB-first on a gated bit
// clock. A hold register prefetches the next word so the stream has no gaps.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle frame request, ignored unless idle
//   mem         : frame-buffer read bus (master side)
//   i2s_clk     : bit clock, CLK_DIV clk low then CLK_DIV clk high per bit
//   i2s_data    : serial data, changes only at the start of a low phase
//   frame_sync  : high for the whole bit period of word 0, bit 0 (MSB)
//   busy        : frame in progress
//   done        : one-cycle end-of-frame pulse
module i2s_frame_streamer #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 1024,
  parameter int CLK_DIV     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  i2s_frame_streamer_if.master mem,
  output logic                i2s_clk,
  output logic                i2s_data,
  output logic                frame_sync,
  output logic                busy,
  output logic                done
);

  localparam int BCW = $clog2(WORD_W);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BCW-1:0]    LAST_BIT  = BCW'(WORD_W - 1);
  localparam logic [WCW-1:0]    LAST_WORD = WCW'(FRAME_WORDS - 1);
  localparam logic [DCW-1:0]    LAST_DIV  = DCW'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  // LOAD issues the word-1 prefetch while word 0 is in flight; PRIME is the
  // cycle word 0 is on the bus and gets captured into the shift register.
  typedef enum logic [2:0] {IDLE, LOAD, PRIME, RUN, FINISH} state_t;

  state_t              state_q, state_d;
  logic [DCW-1:0]      div_q, div_d;
  logic                ph_q, ph_d;        // 0: low phase, 1: high phase
  logic [BCW-1:0]      bit_q, bit_d;
  logic [WCW-1:0]      word_q, word_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_vld_q;          // mem_rd_data valid this cycle
  logic                i2s_clk_q, i2s_clk_d;
  logic                i2s_data_q, i2s_data_d;
  logic                fs_q, fs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    word_d    = word_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;

    // Prefetched words land in the hold register; word 0 goes straight to
    // the shift register in PRIME instead.
    if (rd_vld_q && state_q == RUN) hold_d = mem.mem_rd_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      LOAD: begin
        state_d = PRIME;
        if (rd_addr_q != LAST_ADDR) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      PRIME: begin
        state_d = RUN;
        shreg_d = mem.mem_rd_data;
        div_d   = '0;
        ph_d    = 1'b0;
        bit_d   = '0;
        word_d  = '0;
      end
      RUN: begin
        if (div_q != LAST_DIV) begin
          div_d = div_q + DCW'(1);
        end else begin
          div_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            // End of a bit period: the next bit starts with a low phase.
            ph_d = 1'b0;
            if (bit_q != LAST_BIT) begin
              bit_d   = bit_q + BCW'(1);
              shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            end else begin
              bit_d = '0;
              if (word_q == LAST_WORD) begin
                state_d = FINISH;
                word_d  = '0;
              end else begin
                // Word boundary: reload from hold and refill it with the
                // word after next, a full word period ahead of its use.
                word_d  = word_q + WCW'(1);
                shreg_d = hold_q;
                if (rd_addr_q != LAST_ADDR) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
              end
            end
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    i2s_clk_d  = (state_d == RUN) && ph_d;
    i2s_data_d = (state_d == RUN) && shreg_d[WORD_W-1];
    fs_d       = (state_d == RUN) && (word_d == '0) && (bit_d == '0);
    busy_d     = (state_d == LOAD) || (state_d == PRIME) || (state_d == RUN);
    done_d     = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      ph_q       <= 1'b0;
      bit_q      <= '0;
      word_q     <= '0;
      shreg_q    <= '0;
      hold_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      i2s_clk_q  <= 1'b0;
      i2s_data_q <= 1'b0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      shreg_q    <= shreg_d;
      hold_q     <= hold_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_en_q;
      i2s_clk_q  <= i2s_clk_d;
      i2s_data_q <= i2s_data_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem.mem_rd_en   = rd_en_q;
  assign mem.mem_rd_addr = rd_addr_q;
  assign i2s_clk         = i2s_clk_q;
  assign i2s_data        = i2s_data_q;
  assign frame_sync      = fs_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
